// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the ioctl ROM download engine.
// The entry layout depends on ADDR_W, so loader_entry_t is declared inside the top module.
package ioctl_loader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } loader_state_e;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

  // Byte strobe for a byte whose address LSB is lane.
  function automatic logic [1:0] lane_ds(input logic lane);
    return lane ? DS_HI : DS_LO;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A pop and a push may happen in the same cycle,
// and a push into a full FIFO is accepted when a pop frees a slot in that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;
  localparam logic [PTR_W:0]   CNT_ONE    = 1;
  localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; count/pointers already mark every slot invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ioctl_rom_loader.sv
// Packs the ioctl byte stream into 16-bit strobed words, buffers them, and writes each word
// to all SDRAM ports with a toggle request/acknowledge handshake.
module ioctl_rom_loader
  import ioctl_loader_pkg::*;
#(
  parameter int         N_PORTS    = 2,
  parameter int         ADDR_W     = 23,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'd0
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_downl,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  output logic [N_PORTS-1:0] port_req,
  input  logic [N_PORTS-1:0] port_ack,
  output logic [ADDR_W-1:0]  port_a,
  output logic [1:0]         port_ds,
  output logic [15:0]        port_d,
  output logic               port_we,
  output logic               rom_loaded,
  output logic               overflow,
  output logic               core_reset
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ds;
    logic [15:0]       data;
  } loader_entry_t;

  localparam int ENTRY_W = $bits(loader_entry_t);

  logic              wr_last;
  logic              downl_last;
  logic              index_match;
  logic              accept;
  logic              flush;
  logic              dl_start;
  logic [ADDR_W-1:0] byte_addr;
  logic              lane;
  logic              unused_addr;

  loader_entry_t     pend_q;
  loader_entry_t     pend_d;
  logic              pend_valid_q;
  logic              pend_valid_d;
  loader_entry_t     incoming;
  loader_entry_t     merged;
  loader_entry_t     push_entry;
  loader_entry_t     head;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  loader_state_e     state;
  loader_state_e     state_next;
  logic              ack_done;

  assign byte_addr   = ioctl_addr[ADDR_W:1];
  assign lane        = ioctl_addr[0];
  assign unused_addr = ^ioctl_addr;
  assign index_match = (ioctl_index == ROM_INDEX);
  assign accept      = ioctl_wr & ~wr_last & ioctl_downl & index_match;
  assign flush       = downl_last & ~ioctl_downl;
  assign dl_start    = ioctl_downl & ~downl_last & index_match;
  assign ack_done    = (port_ack == port_req);

  // Byte packing: merge into the pending word when possible, otherwise retire it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    push          = 1'b0;
    push_entry    = pend_q;
    incoming.addr = byte_addr;
    incoming.ds   = lane_ds(lane);
    incoming.data = {ioctl_dout, ioctl_dout};
    merged        = pend_q;
    merged.ds     = pend_q.ds | incoming.ds;
    if (lane) merged.data[15:8] = ioctl_dout;
    else      merged.data[7:0]  = ioctl_dout;

    if (accept) begin
      if (!pend_valid_q) begin
        pend_d       = incoming;
        pend_valid_d = 1'b1;
      end else if (pend_q.addr == byte_addr && (pend_q.ds & incoming.ds) == 2'b00) begin
        if (merged.ds == DS_BOTH) begin
          push         = 1'b1;
          push_entry   = merged;
          pend_valid_d = 1'b0;
        end else begin
          pend_d = merged;
        end
      end else begin
        push   = 1'b1;
        pend_d = incoming;
      end
    end else if (flush && pend_valid_q) begin
      push         = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last      <= 1'b0;
      downl_last   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      wr_last      <= ioctl_wr;
      downl_last   <= ioctl_downl;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (ack_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request outputs are held for the whole handshake; reset resyncs req to ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port_req <= port_ack;
      port_we  <= 1'b0;
      port_a   <= '0;
      port_ds  <= '0;
      port_d   <= '0;
    end else if (pop) begin
      port_req <= ~port_req;
      port_we  <= 1'b1;
      port_a   <= head.addr;
      port_ds  <= head.ds;
      port_d   <= head.data;
    end else if (state == WAIT && ack_done) begin
      port_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      if (dl_start)
        rom_loaded <= 1'b0;
      else if (!ioctl_downl && !pend_valid_q && fifo_empty && state == IDLE)
        rom_loaded <= 1'b1;
      overflow   <= overflow | (push & fifo_full & ~pop);
      core_reset <= ~rom_loaded;
    end
  end

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Scoreboard bench for ioctl_rom_loader: a byte-level reference model predicts issued words,
// a monitor compares every request and the status outputs each cycle.
module tb_ioctl_rom_loader;

  localparam int         N_PORTS    = 2;
  localparam int         ADDR_W     = 23;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] ROM_INDEX  = 8'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [1:0]        ds;
    logic [15:0]       d;
  } tb_word_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               ioctl_downl;
  logic [7:0]         ioctl_index;
  logic               ioctl_wr;
  logic [24:0]        ioctl_addr;
  logic [7:0]         ioctl_dout;
  logic [N_PORTS-1:0] port_req;
  logic [N_PORTS-1:0] port_ack;
  logic [ADDR_W-1:0]  port_a;
  logic [1:0]         port_ds;
  logic [15:0]        port_d;
  logic               port_we;
  logic               rom_loaded;
  logic               overflow;
  logic               core_reset;

  ioctl_rom_loader #(
    .N_PORTS    (N_PORTS),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ROM_INDEX  (ROM_INDEX)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_a      (port_a),
    .port_ds     (port_ds),
    .port_d      (port_d),
    .port_we     (port_we),
    .rom_loaded  (rom_loaded),
    .overflow    (overflow),
    .core_reset  (core_reset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int req_count = 0;
  tb_word_t req_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic               s_rst, s_wr, s_downl;
  logic [7:0]         s_idx, s_dout;
  logic [24:0]        s_addr;
  logic [N_PORTS-1:0] s_ack;

  always @(posedge clk) begin
    s_rst   <= reset;
    s_wr    <= ioctl_wr;
    s_downl <= ioctl_downl;
    s_idx   <= ioctl_index;
    s_addr  <= ioctl_addr;
    s_dout  <= ioctl_dout;
    s_ack   <= port_ack;
  end

  // Reference model state.
  bit                 m_wr_last, m_downl_last;
  bit                 m_pv;
  tb_word_t           m_pend;
  tb_word_t           mf[$];
  tb_word_t           exp_q[$];
  bit                 m_busy;
  logic [N_PORTS-1:0] m_req;
  bit                 m_rom, m_ovf, m_core;

  task automatic model_step();
    bit       do_pop, done, push, set_rom, clr_rom, lane;
    tb_word_t pw, hw;
    logic [1:0] bds;
    if (s_rst) begin
      mf.delete();
      exp_q.delete();
      m_pv = 0; m_busy = 0; m_req = s_ack;
      m_rom = 0; m_ovf = 0; m_core = 1;
      m_wr_last = 0; m_downl_last = 0;
      return;
    end
    do_pop  = !m_busy && mf.size() > 0;
    done    = m_busy && (s_ack == m_req);
    set_rom = !s_downl && !m_pv && mf.size() == 0 && !m_busy;
    clr_rom = s_downl && !m_downl_last && s_idx == ROM_INDEX;
    push    = 0;
    pw      = m_pend;
    if (s_wr && !m_wr_last && s_downl && s_idx == ROM_INDEX) begin
      lane = s_addr[0];
      bds  = lane ? 2'b10 : 2'b01;
      if (m_pv && m_pend.a == s_addr[ADDR_W:1] && (m_pend.ds & bds) == 2'b00) begin
        push = 1;
        pw.ds = m_pend.ds | bds;
        pw.d  = lane ? {s_dout, m_pend.d[7:0]} : {m_pend.d[15:8], s_dout};
        m_pv = 0;
      end else begin
        push = m_pv;
        m_pv = 1;
        m_pend.a  = s_addr[ADDR_W:1];
        m_pend.ds = bds;
        m_pend.d  = {s_dout, s_dout};
      end
    end else if (!s_downl && m_downl_last && m_pv) begin
      push = 1;
      m_pv = 0;
    end
    if (do_pop) hw = mf.pop_front();
    if (push) begin
      if (mf.size() < FIFO_DEPTH) mf.push_back(pw);
      else m_ovf = 1;
    end
    if (do_pop) begin
      exp_q.push_back(hw);
      m_req  = ~m_req;
      m_busy = 1;
    end else if (done) begin
      m_busy = 0;
    end
    m_core = ~m_rom;
    if (clr_rom)      m_rom = 0;
    else if (set_rom) m_rom = 1;
    m_wr_last    = s_wr;
    m_downl_last = s_downl;
  endtask

  logic [N_PORTS-1:0] last_req;
  tb_word_t           last_out;

  task automatic monitor_step();
    tb_word_t w;
    check("port_req", port_req, m_req);
    if (s_rst) begin
      last_req = port_req;
      last_out = '{a: port_a, ds: port_ds, d: port_d};
    end else if (port_req != last_req) begin
      req_count++;
      last_req = port_req;
      last_out = '{a: port_a, ds: port_ds, d: port_d};
      req_log.push_back(last_out);
      if (exp_q.size() == 0) begin
        check("req_without_word", exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        check("req_a", port_a, w.a);
        check("req_ds", port_ds, w.ds);
        check("req_d", port_d, w.d);
      end
    end else if (port_we) begin
      check("wait_stable", {port_a, port_ds, port_d}, last_out);
    end
    check("port_we", port_we, m_busy);
    check("rom_loaded", rom_loaded, m_rom);
    check("overflow", overflow, m_ovf);
    check("core_reset", core_reset, m_core);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
      monitor_step();
    end
  end

  // SDRAM-side responder: per-port ack delay, or hold to withhold the ack.
  int                 ack_dly[N_PORTS];
  bit [N_PORTS-1:0]   ack_hold;
  int                 ack_cnt[N_PORTS];

  initial begin
    port_ack = '0;
    ack_hold = '0;
    for (int i = 0; i < N_PORTS; i++) begin ack_dly[i] = 1; ack_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_PORTS; i++) begin
        if (port_req[i] !== port_ack[i] && !ack_hold[i]) begin
          if (ack_cnt[i] >= ack_dly[i]) begin
            port_ack[i] = port_req[i];
            ack_cnt[i]  = 0;
          end else begin
            ack_cnt[i]++;
          end
        end else begin
          ack_cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input int gap);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    tick(1 + gap);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    tick(1);
  endtask

  task automatic end_dl();
    ioctl_downl = 1'b0;
    tick(1);
  endtask

  task automatic wait_rom(input string name, input int lim);
    for (int i = 0; i < lim && rom_loaded !== 1'b1; i++) tick(1);
    check(name, rom_loaded, 1);
  endtask

  task automatic wait_req(input string name, input int target, input int lim);
    for (int i = 0; i < lim && req_count < target; i++) tick(1);
    check(name, req_count, target);
  endtask

  initial begin
    int         n0, iter, nb;
    logic [7:0] idx;
    logic [24:0] addr;

    reset = 1'b1; ioctl_downl = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    tick(3);
    check("rst_port_a", port_a, 0);
    check("rst_port_ds", port_ds, 0);
    check("rst_port_d", port_d, 0);
    check("rst_port_we", port_we, 0);
    check("rst_port_req", port_req, port_ack);
    check("rst_rom_loaded", rom_loaded, 0);
    check("rst_overflow", overflow, 0);
    check("rst_core_reset", core_reset, 1);
    reset = 1'b0;
    tick(3);

    // Even then odd byte of one word: exactly one full-word request.
    start_dl(ROM_INDEX);
    n0 = req_count;
    send_byte(25'h100, 8'h12, 0);
    send_byte(25'h101, 8'h34, 0);
    tick(4);
    check("t1_req_count", req_count, n0 + 1);
    if (req_log.size() > n0) begin
      check("t1_a", req_log[n0].a, 32'h80);
      check("t1_ds", req_log[n0].ds, 2'b11);
      check("t1_d", req_log[n0].d, 16'h3412);
    end
    end_dl();
    wait_rom("t1_rom_loaded", 50);

    // Two half words, the second retired by the end of the download.
    start_dl(ROM_INDEX);
    n0 = req_count;
    send_byte(25'h100, 8'h12, 0);
    send_byte(25'h104, 8'h56, 0);
    end_dl();
    wait_rom("t2_rom_loaded", 100);
    check("t2_core_reset_hold", core_reset, 1);
    tick(1);
    check("t2_core_reset_drop", core_reset, 0);
    check("t2_req_count", req_count, n0 + 2);
    if (req_log.size() > n0 + 1) begin
      check("t2_a0", req_log[n0].a, 32'h80);
      check("t2_ds0", req_log[n0].ds, 2'b01);
      check("t2_d0", req_log[n0].d, 16'h1212);
      check("t2_a1", req_log[n0+1].a, 32'h82);
      check("t2_ds1", req_log[n0+1].ds, 2'b01);
      check("t2_d1", req_log[n0+1].d, 16'h5656);
    end

    // Port 1 acknowledges five cycles after port 0.
    ack_dly[0] = 2; ack_dly[1] = 7;
    start_dl(ROM_INDEX);
    n0 = req_count;
    send_byte(25'h300, 8'hA1, 0);
    send_byte(25'h301, 8'hB2, 0);
    send_byte(25'h302, 8'hC3, 0);
    send_byte(25'h303, 8'hD4, 0);
    wait_req("t5_first_req", n0 + 1, 20);
    iter = 0;
    while (port_ack[1] !== port_req[1] && iter < 30) begin
      check("t5_no_new_req", req_count, n0 + 1);
      check("t5_we_held", port_we, 1);
      tick(1);
      iter++;
    end
    check("t5_skew_seen", iter >= 4, 1);
    wait_req("t5_second_req", n0 + 2, 30);
    end_dl();
    wait_rom("t5_rom_loaded", 100);
    ack_dly[0] = 1; ack_dly[1] = 1;

    // Non-matching index: ignored entirely.
    n0 = req_count;
    start_dl(8'd1);
    send_byte(25'h500, 8'h11, 0);
    send_byte(25'h501, 8'h22, 0);
    send_byte(25'h502, 8'h33, 0);
    end_dl();
    tick(10);
    check("t6_no_req", req_count, n0);
    check("t6_rom_kept", rom_loaded, 1);

    // Slow acks with ten streamed words: FIFO fills and later words are dropped.
    ack_dly[0] = 20; ack_dly[1] = 20;
    start_dl(ROM_INDEX);
    n0 = req_count;
    for (int k = 0; k < 10; k++) begin
      send_byte(25'h200 + 25'(2 * k), 8'(k), 0);
      send_byte(25'h201 + 25'(2 * k), 8'(8'h80 + k), 0);
    end
    end_dl();
    wait_rom("t3_rom_loaded", 400);
    check("t3_overflow", overflow, 1);
    check("t3_words_dropped", (req_count - n0) < 10, 1);
    ack_dly[0] = 1; ack_dly[1] = 1;

    // Reset while waiting on port 1 with words still buffered.
    ack_dly[0] = 0; ack_hold = 2'b10;
    start_dl(ROM_INDEX);
    n0 = req_count;
    for (int k = 0; k < 3; k++) begin
      send_byte(25'h600 + 25'(2 * k), 8'h40, 0);
      send_byte(25'h601 + 25'(2 * k), 8'h41, 0);
    end
    wait_req("t7_first_req", n0 + 1, 20);
    tick(3);
    check("t7_wait_state", {port_ack[1] ^ port_req[1], port_ack[0] ^ port_req[0]}, 2'b10);
    reset = 1'b1;
    tick(2);
    check("t7_req_resync", port_req, port_ack);
    check("t7_we_low", port_we, 0);
    check("t7_rom_low", rom_loaded, 0);
    check("t7_ovf_cleared", overflow, 0);
    reset = 1'b0;
    ack_hold = '0;
    ack_dly[0] = 1;
    tick(1);
    end_dl();
    tick(10);
    check("t7_fifo_discarded", req_count, n0 + 1);
    wait_rom("t7_rom_loaded", 50);

    // Randomized downloads against the model.
    for (int t = 0; t < 16; t++) begin
      idx = ($urandom_range(0, 5) == 0) ? 8'd1 : ROM_INDEX;
      ack_dly[0] = $urandom_range(0, 4);
      ack_dly[1] = $urandom_range(0, 4);
      start_dl(idx);
      addr = 25'($urandom_range(0, 4095));
      nb = $urandom_range(4, 24);
      for (int b = 0; b < nb; b++) begin
        if (b > 0) begin
          case ($urandom_range(0, 3))
            0, 1:    addr = addr + 25'd1;
            2:       addr = addr;
            default: addr = 25'($urandom_range(0, 4095));
          endcase
        end
        send_byte(addr, 8'($urandom), $urandom_range(0, 2));
      end
      end_dl();
      if (idx == ROM_INDEX) begin
        wait_rom("rnd_rom_loaded", 600);
      end else begin
        tick(5);
        check("rnd_rom_kept", rom_loaded, 1);
      end
    end

    tick(5);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
